// File: rtl/spi_reg_pkg.sv
// Shared constants, state encoding and register map for the SPI register responder.
`timescale 1ns/1ps
package spi_reg_pkg;

   localparam int HDR_BITS   = 16;
   localparam int DATA_BITS  = 32;
   localparam int STAT_BITS  = 8;
   localparam int FRAME_BITS = 56;

   localparam logic [3:0] STAT_MARKER = 4'b1010;

   localparam int ST_ACK = 0;
   localparam int ST_ERR = 1;
   localparam int ST_TMO = 2;
   localparam int ST_RW  = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_RD_WAIT,
      S_DATA,
      S_WR_WAIT,
      S_STAT,
      S_DONE
   } state_t;

   localparam logic [14:0] ADDR_FREQ_0    = 15'h0000;
   localparam logic [14:0] ADDR_FREQ_1    = 15'h0004;
   localparam logic [14:0] ADDR_DATA_0    = 15'h0020;
   localparam logic [14:0] ADDR_DATA_1    = 15'h0024;
   localparam logic [14:0] ADDR_NUM_SAMP  = 15'h0040;
   localparam logic [14:0] ADDR_SAMP_FREQ = 15'h0044;
   localparam logic [14:0] ADDR_STATUS    = 15'h0048;
   localparam logic [14:0] ADDR_EN_CORDIC = 15'h004C;
   localparam logic [14:0] ADDR_RESET_ALL = 15'h0050;

   // Builds the trailing status byte: marker in the top nibble, flags below.
   function automatic logic [7:0] make_status(input logic rw, input logic tmo,
                                              input logic err, input logic ack);
      logic [7:0] s;
      s         = {STAT_MARKER, 4'b0000};
      s[ST_RW]  = rw;
      s[ST_TMO] = tmo;
      s[ST_ERR] = err;
      s[ST_ACK] = ack;
      return s;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with rising/falling edge pulses on the synchronised value.
`timescale 1ns/1ps
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic meta;
   logic prev;

   // Metastability pair followed by one history flop for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         sync <= RST_VAL;
         prev <= RST_VAL;
      end else begin
         meta <= din;
         sync <= meta;
         prev <= sync;
      end
   end

   assign rise = sync & ~prev;
   assign fall = ~sync & prev;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 responder: turns each 56-bit frame into one register bus transaction.
`timescale 1ns/1ps
module spi_reg_slave
   import spi_reg_pkg::*;
#(
   parameter int AW      = 15,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          spi_sck,
   input  logic          spi_ss_n,
   input  logic          spi_mosi,
   output logic          spi_miso,
   output logic          spi_miso_oe,
   output logic [AW-1:0] reg_addr,
   output logic [DW-1:0] reg_wdata,
   output logic          reg_wr,
   output logic          reg_rd,
   input  logic [DW-1:0] reg_rdata,
   input  logic          reg_ack,
   input  logic          reg_err
);

   localparam int              TW        = $clog2(TIMEOUT + 1);
   localparam logic [5:0]      LAST_HDR  = 6'(HDR_BITS - 1);
   localparam logic [5:0]      LAST_DATA = 6'(HDR_BITS + DATA_BITS - 1);
   localparam logic [5:0]      LAST_STAT = 6'(FRAME_BITS - 1);
   localparam logic [TW-1:0]   LAST_WAIT = TW'(TIMEOUT - 1);

   logic sck_s, sck_rise, sck_fall;
   logic ss_n_s, ss_rise, ss_fall;
   logic mosi_s, mosi_rise, mosi_fall;
   logic unused_sync;

   state_t                state, next_state;
   logic [5:0]            bit_cnt;
   logic [TW-1:0]         wait_cnt;
   logic                  wait_done;
   logic [AW-1:0]         hdr_sh;
   logic                  rw;
   logic [DW-1:0]         tx_sh;
   logic [STAT_BITS-1:0]  stat_sh;
   logic                  miso_q;

   spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
      .clk  (clk),
      .rst  (rst),
      .din  (spi_sck),
      .sync (sck_s),
      .rise (sck_rise),
      .fall (sck_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_ss_n (
      .clk  (clk),
      .rst  (rst),
      .din  (spi_ss_n),
      .sync (ss_n_s),
      .rise (ss_rise),
      .fall (ss_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
      .clk  (clk),
      .rst  (rst),
      .din  (spi_mosi),
      .sync (mosi_s),
      .rise (mosi_rise),
      .fall (mosi_fall)
   );

   assign unused_sync = ^{sck_s, ss_rise, ss_fall, mosi_rise, mosi_fall};
   assign wait_done   = (wait_cnt == LAST_WAIT);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; a deselected chip select overrides everything.
   always_comb begin
      next_state = state;
      if (ss_n_s) begin
         next_state = S_IDLE;
      end else begin
         case (state)
            S_IDLE:    next_state = S_HDR;
            S_HDR:     if (sck_rise && bit_cnt == LAST_HDR)
                          next_state = hdr_sh[AW-1] ? S_RD_WAIT : S_DATA;
            S_RD_WAIT: if (reg_ack || wait_done) next_state = S_DATA;
            S_DATA:    if (sck_rise && bit_cnt == LAST_DATA)
                          next_state = rw ? S_STAT : S_WR_WAIT;
            S_WR_WAIT: if (reg_ack || wait_done) next_state = S_STAT;
            S_STAT:    if (sck_rise && bit_cnt == LAST_STAT) next_state = S_DONE;
            S_DONE:    next_state = S_DONE;
            default:   next_state = S_IDLE;
         endcase
      end
   end

   // Pin outputs: MISO only drives shifted bits during the data and status phases.
   always_comb begin
      spi_miso_oe = ~ss_n_s;
      spi_miso    = 1'b0;
      if (!ss_n_s && (state == S_DATA || state == S_STAT)) begin
         spi_miso = miso_q;
      end
   end

   // Frame datapath: bit counting, shift registers, bus strobes and status capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt   <= '0;
         wait_cnt  <= '0;
         hdr_sh    <= '0;
         rw        <= 1'b0;
         tx_sh     <= '0;
         stat_sh   <= '0;
         miso_q    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_rd    <= 1'b0;
         reg_wr    <= 1'b0;
      end else begin
         reg_rd <= (state == S_HDR)  && (next_state == S_RD_WAIT);
         reg_wr <= (state == S_DATA) && (next_state == S_WR_WAIT);
         case (state)
            S_IDLE: begin
               bit_cnt  <= '0;
               wait_cnt <= '0;
               tx_sh    <= '0;
               stat_sh  <= '0;
               miso_q   <= 1'b0;
            end
            S_HDR: begin
               if (sck_rise) begin
                  hdr_sh  <= {hdr_sh[AW-2:0], mosi_s};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_HDR) begin
                     reg_addr <= {hdr_sh[AW-2:0], mosi_s};
                     rw       <= hdr_sh[AW-1];
                  end
               end
            end
            S_RD_WAIT, S_WR_WAIT: begin
               if (reg_ack) begin
                  if (state == S_RD_WAIT) tx_sh <= reg_rdata;
                  stat_sh <= make_status(rw, 1'b0, reg_err, ~reg_err);
               end else if (wait_done) begin
                  tx_sh   <= '0;
                  stat_sh <= make_status(rw, 1'b1, 1'b0, 1'b0);
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (sck_fall) begin
                  miso_q <= tx_sh[DW-1];
                  tx_sh  <= {tx_sh[DW-2:0], 1'b0};
               end
               if (sck_rise) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (!rw) reg_wdata <= {reg_wdata[DW-2:0], mosi_s};
               end
            end
            S_STAT: begin
               if (sck_fall) begin
                  miso_q  <= stat_sh[STAT_BITS-1];
                  stat_sh <= {stat_sh[STAT_BITS-2:0], 1'b0};
               end
               if (sck_rise) bit_cnt <= bit_cnt + 1'b1;
            end
            S_DONE: begin
               miso_q <= 1'b0;
            end
            default: begin
               miso_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Scoreboard bench for spi_reg_slave: SPI host driver, register bus responder, two monitors.
`timescale 1ns/1ps
module tb_spi_reg_slave;
   import spi_reg_pkg::*;

   localparam int HALF    = 25;
   localparam int GAP     = 10;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        spi_sck, spi_ss_n, spi_mosi;
   logic        spi_miso, spi_miso_oe;
   logic [14:0] reg_addr;
   logic [31:0] reg_wdata;
   logic        reg_wr, reg_rd;
   logic [31:0] reg_rdata;
   logic        reg_ack, reg_err;

   typedef struct packed {
      logic        is_write;
      logic [14:0] addr;
      logic [31:0] wdata;
   } bus_exp_t;

   typedef struct packed {
      logic        is_read;
      logic [31:0] data;
      logic [7:0]  status;
   } resp_exp_t;

   bus_exp_t    exp_bus_q[$];
   resp_exp_t   exp_resp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cfg_delay;
   logic        cfg_err;
   logic [31:0] cfg_rdata;
   logic        cfg_stray;
   logic [55:0] got_frame;
   event        frame_done;

   spi_reg_slave #(.AW(15), .DW(32), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .spi_sck     (spi_sck),
      .spi_ss_n    (spi_ss_n),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .reg_addr    (reg_addr),
      .reg_wdata   (reg_wdata),
      .reg_wr      (reg_wr),
      .reg_rd      (reg_rd),
      .reg_rdata   (reg_rdata),
      .reg_ack     (reg_ack),
      .reg_err     (reg_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Status byte from the frame rules: marker, rw echo, then timeout / error / ack.
   function automatic logic [7:0] model_status(input bit is_read, input int delay,
                                               input bit err);
      bit         acked;
      logic [7:0] s;
      acked = (delay >= 0) && (delay < TIMEOUT);
      s     = 8'hA0;
      if (is_read) s = s + 8'h08;
      if (!acked)  s = s + 8'h04;
      else if (err) s = s + 8'h02;
      else          s = s + 8'h01;
      return s;
   endfunction

   // SPI host: drives one frame (or the first nbits of it) and captures MISO on each rise.
   task automatic applyStimulus(input logic is_read, input logic [14:0] addr,
                                input logic [31:0] wdata, input int nbits,
                                input bit release_ss);
      logic [47:0] tx;
      logic [55:0] rx;
      tx = {is_read, addr, wdata};
      rx = '0;
      @(negedge clk);
      spi_ss_n = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = (i < 48) ? tx[47 - i] : 1'b0;
         repeat (HALF) @(negedge clk);
         rx[55 - i] = spi_miso;
         spi_sck = 1'b1;
         repeat (HALF) @(negedge clk);
         spi_sck = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      if (release_ss) begin
         spi_ss_n = 1'b1;
         spi_mosi = 1'b0;
         repeat (GAP) @(negedge clk);
      end
      if (nbits == 56) begin
         got_frame = rx;
         -> frame_done;
      end
   endtask

   task automatic run_frame(input bit is_read, input logic [14:0] addr,
                            input logic [31:0] wdata, input int delay,
                            input bit err, input logic [31:0] rdata);
      bus_exp_t  b;
      resp_exp_t r;
      cfg_delay  = delay;
      cfg_err    = err;
      cfg_rdata  = rdata;
      b.is_write = !is_read;
      b.addr     = addr;
      b.wdata    = wdata;
      exp_bus_q.push_back(b);
      r.is_read  = is_read;
      r.data     = ((delay >= 0) && (delay < TIMEOUT)) ? rdata : 32'h0;
      r.status   = model_status(is_read, delay, err);
      exp_resp_q.push_back(r);
      applyStimulus(is_read, addr, wdata, 56, 1'b1);
   endtask

   // Register bus responder: acks cfg_delay cycles after a strobe, optional stray acks.
   initial begin
      int ack_cnt;
      ack_cnt   = -1;
      reg_ack   = 1'b0;
      reg_err   = 1'b0;
      reg_rdata = '0;
      forever begin
         @(negedge clk);
         reg_ack = 1'b0;
         reg_err = 1'b0;
         if (reg_rd || reg_wr) ack_cnt = cfg_delay;
         if (ack_cnt == 0) begin
            reg_ack   = 1'b1;
            reg_err   = cfg_err;
            reg_rdata = cfg_rdata;
         end else if (ack_cnt < 0 && cfg_stray && cfg_delay >= 0 &&
                      $urandom_range(0, 15) == 0) begin
            reg_ack   = 1'b1;
            reg_err   = 1'b1;
            reg_rdata = $urandom;
         end
         if (ack_cnt >= 0) ack_cnt--;
      end
   end

   // Bus monitor: every strobe must match the next expected transaction.
   initial begin
      bus_exp_t e;
      forever begin
         @(negedge clk);
         if (reg_wr || reg_rd) begin
            if (exp_bus_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_strobe: got wr=%0b rd=%0b addr=0x%0h, expected none",
                        reg_wr, reg_rd, reg_addr);
            end else begin
               e = exp_bus_q.pop_front();
               checkOutput("bus_is_write", {63'd0, reg_wr}, {63'd0, e.is_write});
               checkOutput("bus_addr", {49'd0, reg_addr}, {49'd0, e.addr});
               if (e.is_write) checkOutput("bus_wdata", {32'd0, reg_wdata}, {32'd0, e.wdata});
            end
         end
      end
   end

   // Frame monitor: compares captured MISO against the expected response.
   initial begin
      resp_exp_t r;
      forever begin
         @(frame_done);
         if (exp_resp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_frame: got frame 0x%0h, expected none", got_frame);
         end else begin
            r = exp_resp_q.pop_front();
            checkOutput("miso_header", {48'd0, got_frame[55:40]}, 64'd0);
            if (r.is_read) checkOutput("miso_rdata", {32'd0, got_frame[39:8]}, {32'd0, r.data});
            checkOutput("miso_status", {56'd0, got_frame[7:0]}, {56'd0, r.status});
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: got no end of test, expected finish before 2ms");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: directed frames from the test plan, then randomized frames.
   initial begin
      bus_exp_t    b;
      bit          rd;
      logic [14:0] a;
      int          d;
      bit          e;
      rst       = 1'b1;
      spi_sck   = 1'b0;
      spi_ss_n  = 1'b1;
      spi_mosi  = 1'b0;
      cfg_delay = 0;
      cfg_err   = 1'b0;
      cfg_rdata = '0;
      cfg_stray = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_miso", {63'd0, spi_miso}, 64'd0);
      checkOutput("reset_miso_oe", {63'd0, spi_miso_oe}, 64'd0);
      checkOutput("reset_reg_wr", {63'd0, reg_wr}, 64'd0);
      checkOutput("reset_reg_rd", {63'd0, reg_rd}, 64'd0);
      checkOutput("reset_reg_addr", {49'd0, reg_addr}, 64'd0);
      checkOutput("reset_reg_wdata", {32'd0, reg_wdata}, 64'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      $display("[TB] directed frames");
      run_frame(1'b0, ADDR_NUM_SAMP, 32'h0000_03E8, 0, 1'b0, 32'h0);
      run_frame(1'b1, ADDR_NUM_SAMP, 32'h0, 2, 1'b0, 32'h1234_5678);
      run_frame(1'b1, ADDR_NUM_SAMP, 32'h0, -1, 1'b0, 32'hDEAD_BEEF);
      run_frame(1'b0, ADDR_NUM_SAMP, 32'h0000_55AA, 0, 1'b1, 32'h0);

      $display("[TB] aborted write then full write");
      cfg_delay = 0;
      cfg_err   = 1'b0;
      applyStimulus(1'b0, ADDR_SAMP_FREQ, 32'h0000_1388, 40, 1'b1);
      run_frame(1'b0, ADDR_SAMP_FREQ, 32'h0000_1388, 0, 1'b0, 32'h0);

      $display("[TB] reset during read data phase");
      b.is_write = 1'b0;
      b.addr     = ADDR_NUM_SAMP;
      b.wdata    = 32'h0;
      exp_bus_q.push_back(b);
      cfg_delay = 1;
      cfg_err   = 1'b0;
      cfg_rdata = 32'hA5A5_0F0F;
      applyStimulus(1'b1, ADDR_NUM_SAMP, 32'h0, 30, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_miso", {63'd0, spi_miso}, 64'd0);
      checkOutput("rst_mid_miso_oe", {63'd0, spi_miso_oe}, 64'd0);
      checkOutput("rst_mid_state", {61'd0, dut.state}, {61'd0, S_IDLE});
      checkOutput("rst_mid_reg_rd", {63'd0, reg_rd}, 64'd0);
      checkOutput("rst_mid_reg_wr", {63'd0, reg_wr}, 64'd0);
      repeat (3) @(negedge clk);
      rst      = 1'b0;
      spi_ss_n = 1'b1;
      spi_mosi = 1'b0;
      repeat (GAP) @(negedge clk);
      run_frame(1'b1, ADDR_FREQ_0, 32'h0, 1, 1'b0, 32'hCAFE_F00D);

      $display("[TB] randomized frames");
      cfg_stray = 1'b1;
      for (int k = 0; k < 8; k++) begin
         rd = bit'($urandom_range(0, 1));
         a  = 15'($urandom_range(0, 32767));
         d  = int'($urandom_range(0, 11));
         if (d > 10) d = -1;
         e  = ($urandom_range(0, 3) == 0);
         run_frame(rd, a, $urandom, d, e, $urandom);
      end
      cfg_stray = 1'b0;

      repeat (20) @(negedge clk);
      checkOutput("bus_queue_drained", 64'(exp_bus_q.size()), 64'd0);
      checkOutput("resp_queue_drained", 64'(exp_resp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
